vrf_masked_csr: RTL and testbench
=================================

// Module: vrf_masked_csr
// PURPOSE
//  Parametrised vector register file with the vl/vtype CSR pair and a vsetvl unit.
//  Generalises the fixed 32x128b VRF:
//   - element-granular writes, gated by vl (tail policy) and by the v0 mask;
//   - an on-chip vsetvl computation (VLMAX, AVL clamping, vill detection).
//  Sits between vector decode/issue (CSR updates) and the vector lanes (operand reads, result writeback).
// PARAMETERS
//  VLEN   128  bits per vector register (power of 2, >=64)
//  NREG   32   number of architectural vector registers
//  ELEN   64   max supported SEW in bits (8..64)
//  VL_W   9    width of vl; must hold VLEN (SEW=8, LMUL=8 -> VLMAX=VLEN)
//  AVL_W  32   width of requested AVL
// PORTS
//  clk         in   1                 clock, rising edge
//  rst         in   1                 synchronous, active-high reset
//  raA, raB    in   $clog2(NREG)      read addresses
//  rdA, rdB    out  VLEN              read data, combinational
//  wa          in   $clog2(NREG)      write address
//  wd          in   VLEN              write data
//  wen         in   1                 write enable
//  w_grp       in   3                 index of wa within its LMUL group (0..7)
//  w_masked    in   1                 1: apply v0 mask to this write
//  w_whole     in   1                 1: write all VLEN bits, ignore vl/mask/tail
//  vset_en     in   1                 vsetvl request (single-cycle pulse)
//  vset_mode   in   2                 0: vl=min(avl,VLMAX)  1: vl=VLMAX  2: keep vl  3: reserved
//  avl         in   AVL_W             requested application vector length
//  vtype_in    in   7                 [6]=vta, [5:3]=vsew, [2:0]=vlmul
//  vl          out  VL_W              current vl
//  vtype       out  7                 current vtype
//  vill        out  1                 current vtype is illegal
//  vlmax       out  VL_W              VLMAX for current vtype (0 when vill)
// BEHAVIOUR
//  - Reset: all NREG registers = 0, vl = 0, vtype = 0, vill = 1; vlmax = 0.
//  - Reads: combinational. Reading the register being written in the same cycle returns pre-write data (no bypass).
//  - Writes commit at the rising edge when wen=1; write state uses pre-update vl/vtype.
//  - Element write rules (w_whole=0):
//    * SEW = 8<<vsew, EPR = VLEN/SEW, element e of wa has global index g = w_grp*EPR + e.
//    * body, g < vl: written if !w_masked, or if v0 bit g = 1 (v0 = reg 0, bit g of its current contents); otherwise kept.
//    * tail, g >= vl: vta=0 keeps old bits; vta=1 writes all-ones.
//    * vill=1: every element is treated as tail with vta=0, so only w_whole writes modify state.
//  - w_whole=1: full VLEN bits written regardless of vl, vtype, vill or mask.
//  - Legal vtype: vsew <= 3, (8<<vsew) <= ELEN, vlmul in {0,1,2,3} (LMUL = 1,2,4,8).
//    Fractional/reserved vlmul (4..7) is illegal.
//  - VLMAX = (VLEN / SEW) << vlmul.
//  - vset_en=1 updates the CSRs at the next edge:
//    * illegal vtype_in or vset_mode=3: vill=1, vtype=0, vl=0.
//    * mode 0: vl = (avl >= VLMAX) ? VLMAX : avl (full AVL_W compare; no truncation before compare).
//    * mode 1: vl = VLMAX.
//    * mode 2: vl unchanged if old vl <= new VLMAX and vill was 0; otherwise vill=1, vtype=0, vl=0.
//    * otherwise vill=0 and vtype = vtype_in.
//  - wen and vset_en in the same cycle: write uses old CSRs, CSRs update at the same edge.
//  - A write with wa=0 and w_masked=1 samples v0 before the update.
//  - rst has priority over wen and vset_en in the same cycle.
//  - A mid-sequence rst restores all reset values on that edge.
// TESTING
//  1. rst=1 one cycle -> vl=0, vtype=0, vill=1, vlmax=0, rdA(any reg)=0.
//  2. vset mode0, avl=100, vtype_in={0,3'd0,3'd1} (SEW8, LMUL2) -> vlmax=32, vl=32, vill=0.
//     Then avl=5 -> vl=5.
//  3. vl=5, SEW8, vta=0, reg3=all-0xAA; write wa=3, wd=all-0x11, w_grp=0
//     -> rdA(3) bytes 0..4 = 0x11, bytes 5..15 = 0xAA.
//     Repeat with vta=1 -> bytes 5..15 = 0xFF.
//  4. v0=16'h0005 (bits 0,2), vl=16, SEW8, w_masked=1, write reg2 = all-0x22
//     -> only bytes 0 and 2 = 0x22; others keep old value.
//  5. vtype_in vsew=3 with ELEN=32, or vlmul=5 -> vill=1, vl=0, vtype=0.
//     Then w_whole write to reg1 = 128'hDEAD... -> rdB(1) = 128'hDEAD...
//  6. Same cycle: wen to reg4 (w_grp=1, SEW16, vl=10, old CSRs) and vset_en mode1
//     -> reg4 elements 0,1 written, 2..7 tail; new vl = VLMAX of vtype_in.

Source files
------------

// File: rtl/vrf_masked_csr.sv
// vrf_masked_csr
//   Vector register file with the vl/vtype CSR pair and a vsetvl unit.
//   Writes are element granular: body elements (global index < vl) are
//   written unless masked off by v0, tail elements are kept or set to all-ones
//   depending on vta, and w_whole bypasses all of that. vsetvl computes VLMAX,
//   clamps AVL and flags illegal vtype encodings.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   raA/raB -> rdA/rdB  two combinational read ports (no write bypass)
//   wa, wd, wen         write address, data, enable
//   w_grp               position of wa inside its LMUL register group
//   w_masked, w_whole   apply v0 mask / write full register unconditionally
//   vset_en, vset_mode  vsetvl request and flavour (0 avl, 1 max, 2 keep vl)
//   avl, vtype_in       requested length and vtype {vta, vsew, vlmul}
//   vl, vtype, vill     current CSR state
//   vlmax               VLMAX of the current vtype, 0 while vill
module vrf_masked_csr #(
  parameter int VLEN  = 128,
  parameter int NREG  = 32,
  parameter int ELEN  = 64,
  parameter int VL_W  = 9,
  parameter int AVL_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] raA,
  input  logic [$clog2(NREG)-1:0] raB,
  output logic [VLEN-1:0]         rdA,
  output logic [VLEN-1:0]         rdB,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [VLEN-1:0]         wd,
  input  logic                    wen,
  input  logic [2:0]              w_grp,
  input  logic                    w_masked,
  input  logic                    w_whole,
  input  logic                    vset_en,
  input  logic [1:0]              vset_mode,
  input  logic [AVL_W-1:0]        avl,
  input  logic [6:0]              vtype_in,
  output logic [VL_W-1:0]         vl,
  output logic [6:0]              vtype,
  output logic                    vill,
  output logic [VL_W-1:0]         vlmax
);

  localparam int NB = VLEN / 8;           // bytes per register
  localparam int GW = $clog2(VLEN) + 1;   // holds any global element index

  function automatic logic f_legal(input logic [6:0] t);
    return (t[5:3] <= 3'd3) && ((8 << t[5:3]) <= ELEN) && !t[2];
  endfunction

  // Only meaningful for legal vtypes: (VLEN/SEW) << LMUL.
  function automatic logic [VL_W-1:0] f_vlmax(input logic [6:0] t);
    return VL_W'((NB >> t[5:3]) << t[1:0]);
  endfunction

  logic [VLEN-1:0] r_vrf [NREG];
  logic [VL_W-1:0] r_vl;
  logic [6:0]      r_vtype;
  logic            r_vill;

  logic [VLEN-1:0] w_old;
  logic [VLEN-1:0] w_v0;
  logic [VLEN-1:0] w_wdata;
  logic [VL_W-1:0] w_new_vlmax;
  logic            w_bad;
  logic [VL_W-1:0] w_vl_next;
  logic [6:0]      w_vtype_next;
  logic            w_vill_next;

  assign rdA   = r_vrf[raA];
  assign rdB   = r_vrf[raB];
  assign w_old = r_vrf[wa];
  assign w_v0  = r_vrf[0];

  assign vl    = r_vl;
  assign vtype = r_vtype;
  assign vill  = r_vill;
  assign vlmax = r_vill ? '0 : f_vlmax(r_vtype);

  // Merge of new and old data, one byte at a time. SEW is a multiple of 8,
  // so every byte of an element resolves to the same global index.
  // While vill is set r_vtype is 0, so the index arithmetic stays in range.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      logic [GW-1:0] w_g;
      logic          w_body;
      logic          w_v0b;
      assign w_g    = GW'(w_grp) * (GW'(NB) >> r_vtype[5:3])
                    + (GW'(gi) >> r_vtype[5:3]);
      assign w_body = 32'(w_g) < 32'(r_vl);
      assign w_v0b  = w_v0[w_g[GW-2:0]];
      assign w_wdata[gi*8 +: 8] =
          w_whole ? wd[gi*8 +: 8] :
          r_vill  ? w_old[gi*8 +: 8] :
          w_body  ? ((!w_masked || w_v0b) ? wd[gi*8 +: 8] : w_old[gi*8 +: 8]) :
          (r_vtype[6] ? 8'hFF : w_old[gi*8 +: 8]);
    end
  endgenerate

  // vsetvl next-state.
  always_comb begin
    w_vl_next    = r_vl;
    w_vtype_next = r_vtype;
    w_vill_next  = r_vill;
    w_new_vlmax  = f_vlmax(vtype_in);
    w_bad        = !f_legal(vtype_in) || (vset_mode == 2'd3) ||
                   ((vset_mode == 2'd2) && (r_vill || (r_vl > w_new_vlmax)));
    if (vset_en) begin
      if (w_bad) begin
        w_vill_next  = 1'b1;
        w_vtype_next = '0;
        w_vl_next    = '0;
      end else begin
        w_vill_next  = 1'b0;
        w_vtype_next = vtype_in;
        case (vset_mode)
          2'd0: begin
            // Compare at full AVL width so large AVLs never alias small ones.
            if (64'(avl) >= 64'(w_new_vlmax)) w_vl_next = w_new_vlmax;
            else                              w_vl_next = VL_W'(avl);
          end
          2'd1:    w_vl_next = w_new_vlmax;
          default: w_vl_next = r_vl;
        endcase
      end
    end
  end

  // The write merge above reads the pre-edge CSRs and v0, so a write that
  // coincides with vsetvl or targets v0 sees the old state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_vrf[i] <= '0;
      r_vl    <= '0;
      r_vtype <= '0;
      r_vill  <= 1'b1;
    end else begin
      if (wen) r_vrf[wa] <= w_wdata;
      r_vl    <= w_vl_next;
      r_vtype <= w_vtype_next;
      r_vill  <= w_vill_next;
    end
  end

endmodule

// File: tb/tb_vrf_masked_csr.sv
module tb_vrf_masked_csr;

  localparam int VLEN = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [4:0]     raA, raB, wa;
  logic [127:0]   rdA, rdB, wd;
  logic           wen, w_masked, w_whole, vset_en;
  logic [2:0]     w_grp;
  logic [1:0]     vset_mode;
  logic [31:0]    avl;
  logic [6:0]     vtype_in, vtype;
  logic [8:0]     vl, vlmax;
  logic           vill;

  vrf_masked_csr dut (
    .clk(clk), .rst(rst), .raA(raA), .raB(raB), .rdA(rdA), .rdB(rdB),
    .wa(wa), .wd(wd), .wen(wen), .w_grp(w_grp), .w_masked(w_masked),
    .w_whole(w_whole), .vset_en(vset_en), .vset_mode(vset_mode), .avl(avl),
    .vtype_in(vtype_in), .vl(vl), .vtype(vtype), .vill(vill), .vlmax(vlmax)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [127:0] m_reg [32];
  int           m_vl;
  logic [6:0]   m_vtype;
  bit           m_vill;
  bit           chk_en = 0;

  int n_vec = 0;
  int n_mis = 0;

  function automatic int vlmax_of(logic [6:0] t);
    return (VLEN / (8 << t[5:3])) << t[2:0];
  endfunction

  function automatic int exp_vlmax();
    return m_vill ? 0 : vlmax_of(m_vtype);
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hand-computed expectation applied to both DUT and model.
  task automatic lit(string nm, logic [127:0] act, logic [127:0] mdl, logic [127:0] exp);
    $display("lit %s exp=%h", nm, exp);
    check({nm, "_dut"}, act, exp);
    check({nm, "_model"}, mdl, exp);
  endtask

  task automatic model_update();
    logic [127:0] nv, v0;
    int sew, epr, g, nvl;
    bit legal, bad;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_vl = 0; m_vtype = '0; m_vill = 1;
      return;
    end
    nv = m_reg[wa];
    v0 = m_reg[0];
    if (wen) begin
      if (w_whole) nv = wd;
      else if (!m_vill) begin
        sew = 8 << m_vtype[5:3];
        epr = VLEN / sew;
        for (int b = 0; b < VLEN; b++) begin
          g = int'(w_grp) * epr + b / sew;
          if (g < m_vl) begin
            if (!w_masked || v0[g]) nv[b] = wd[b];
          end else if (m_vtype[6]) nv[b] = 1'b1;
        end
      end
    end
    if (vset_en) begin
      legal = (vtype_in[5:3] <= 3) && ((8 << vtype_in[5:3]) <= 64) && (vtype_in[2:0] <= 3);
      nvl   = legal ? vlmax_of(vtype_in) : 0;
      bad   = !legal || vset_mode == 3 || (vset_mode == 2 && (m_vill || m_vl > nvl));
      if (bad) begin
        m_vill = 1; m_vtype = '0; m_vl = 0;
      end else begin
        m_vill = 0; m_vtype = vtype_in;
        if (vset_mode == 0) m_vl = ({32'd0, avl} >= 64'(nvl)) ? nvl : int'(avl);
        else if (vset_mode == 1) m_vl = nvl;
      end
    end
    if (wen) m_reg[wa] = nv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    rst = 0; wen = 0; vset_en = 0; w_whole = 0; w_masked = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [127:0] d, input logic [2:0] grp,
                    input logic msk, input logic whole);
    wa = a; wd = d; w_grp = grp; w_masked = msk; w_whole = whole; wen = 1;
    tick();
  endtask

  task automatic vs(input logic [1:0] mode, input logic [31:0] a, input logic [6:0] vt);
    vset_en = 1; vset_mode = mode; avl = a; vtype_in = vt;
    tick();
  endtask

  task automatic peek(input logic [4:0] a);
    raA = a; raB = a;
    #1;
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdA", rdA, m_reg[raA]);
      check("rdB", rdB, m_reg[raB]);
      check("vl", 128'(vl), 128'(m_vl));
      check("vtype", 128'(vtype), 128'(m_vtype));
      check("vill", 128'(vill), 128'(m_vill));
      check("vlmax", 128'(vlmax), 128'(exp_vlmax()));
    end
  end

  initial begin
    rst = 1; raA = 0; raB = 0; wa = 0; wd = '0; wen = 0; w_grp = 0;
    w_masked = 0; w_whole = 0; vset_en = 0; vset_mode = 0; avl = 0; vtype_in = 0;
    tick();
    chk_en = 1;

    // Reset state
    peek(5);
    lit("rst_vl", 128'(vl), 128'(m_vl), 128'd0);
    lit("rst_vill", 128'(vill), 128'(m_vill), 128'd1);
    lit("rst_vlmax", 128'(vlmax), 128'(exp_vlmax()), 128'd0);
    lit("rst_reg5", rdA, m_reg[5], 128'd0);

    // SEW8 LMUL2
    vs(0, 100, 7'b0_000_001);
    lit("vset_vlmax32", 128'(vlmax), 128'(exp_vlmax()), 128'd32);
    lit("vset_vl32", 128'(vl), 128'(m_vl), 128'd32);
    vs(0, 5, 7'b0_000_001);
    lit("vset_vl5", 128'(vl), 128'(m_vl), 128'd5);

    // Tail undisturbed, then tail agnostic
    wr(3, {16{8'hAA}}, 0, 0, 1);
    wr(3, {16{8'h11}}, 0, 0, 0);
    peek(3);
    lit("tail_keep", rdA, m_reg[3], {{11{8'hAA}}, {5{8'h11}}});
    vs(2, 0, 7'b1_000_001);
    lit("keep_vl5", 128'(vl), 128'(m_vl), 128'd5);
    wr(3, {16{8'hAA}}, 0, 0, 1);
    wr(3, {16{8'h11}}, 0, 0, 0);
    peek(3);
    lit("tail_ones", rdA, m_reg[3], {{11{8'hFF}}, {5{8'h11}}});

    // Masked write with v0 = 0x5
    wr(0, 128'h5, 0, 0, 1);
    vs(0, 16, 7'b0_000_000);
    wr(2, {16{8'h33}}, 0, 0, 1);
    wr(2, {16{8'h22}}, 0, 1, 0);
    peek(2);
    lit("masked", rdA, m_reg[2], {{13{8'h33}}, 8'h22, 8'h33, 8'h22});

    // Illegal vtype, whole write still lands, element write does not
    vs(0, 16, 7'b0_000_101);
    lit("ill_vill", 128'(vill), 128'(m_vill), 128'd1);
    lit("ill_vl", 128'(vl), 128'(m_vl), 128'd0);
    wr(1, {4{32'hDEADBEEF}}, 0, 0, 1);
    wr(1, '0, 0, 0, 0);
    peek(1);
    lit("whole_ill", rdB, m_reg[1], {4{32'hDEADBEEF}});
    vs(1, 0, 7'b0_100_000);
    lit("sew128_ill", 128'(vill), 128'(m_vill), 128'd1);

    // Write and vsetvl in the same cycle
    vs(0, 10, 7'b0_001_001);
    lit("sew16_vl10", 128'(vl), 128'(m_vl), 128'd10);
    wr(4, {16{8'h44}}, 0, 0, 1);
    wa = 4; wd = {16{8'h66}}; w_grp = 1; wen = 1;
    vset_en = 1; vset_mode = 1; vtype_in = 7'b0_000_011;
    tick();
    peek(4);
    lit("same_cycle_reg", rdA, m_reg[4], {{12{8'h44}}, {4{8'h66}}});
    lit("same_cycle_vl", 128'(vl), 128'(m_vl), 128'd128);

    // Keep-vl mode that cannot keep
    vs(2, 0, 7'b0_000_000);
    lit("keep_fail", 128'(vill), 128'(m_vill), 128'd1);

    // Large AVL must not truncate
    vs(0, 32'hFFFF_FF05, 7'b0_000_000);
    lit("big_avl", 128'(vl), 128'(m_vl), 128'd16);

    // Reset beats write and vsetvl
    rst = 1; wa = 4; wd = '1; w_whole = 1; wen = 1; vset_en = 1; vset_mode = 1;
    tick();
    peek(4);
    lit("rst_prio_reg", rdA, m_reg[4], 128'd0);
    lit("rst_prio_vill", 128'(vill), 128'(m_vill), 128'd1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      wen       = 1'($urandom_range(0, 1));
      wa        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      wd        = {$urandom, $urandom, $urandom, $urandom};
      w_grp     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      w_masked  = 1'($urandom_range(0, 1));
      w_whole   = ($urandom_range(0, 7) == 0);
      vset_en   = ($urandom_range(0, 3) == 0);
      vset_mode = 2'($urandom_range(0, 3));
      avl       = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 140)) : $urandom;
      vtype_in  = ($urandom_range(0, 3) != 0) ?
                  {1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))} :
                  7'($urandom);
      raA       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      raB       = 5'($urandom_range(0, 7));
      $display("rand %0d rst=%0b wen=%0b wa=%0d grp=%0d m=%0b w=%0b vset=%0b mode=%0d avl=%0d vt=%h",
               n, rst, wen, wa, w_grp, w_masked, w_whole, vset_en, vset_mode, avl, vtype_in);
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
